// File: rtl/vga_timing_2015.sv
// 640x480@60 VGA timing generator: free-running pixel/line counters plus
// registered sync, blanked colour and frame tick, all one clock behind xpos/ypos.
module vga_timing_2015 #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk25,
  input  logic       Reset,
  input  logic [2:0] red_in,
  input  logic [2:0] green_in,
  input  logic [1:0] blue_in,
  output logic [9:0] xpos,
  output logic [9:0] ypos,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] red,
  output logic [2:0] green,
  output logic [1:0] blue,
  output logic       frame_tick
);

  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [9:0] xpos_q, xpos_d, ypos_q, ypos_d;
  logic       hsync_q, hsync_d, vsync_q, vsync_d, tick_q, tick_d;
  logic [2:0] red_q, red_d, green_q, green_d;
  logic [1:0] blue_q, blue_d;
  logic       visible;

  always_comb begin
    xpos_d = xpos_q + 10'd1;
    ypos_d = ypos_q;
    if (xpos_q == H_LAST) begin
      xpos_d = '0;
      ypos_d = (ypos_q == V_LAST) ? '0 : ypos_q + 10'd1;
    end
    // Everything below describes the pixel currently addressed; it lands one clock later.
    visible = (xpos_q < H_VIS) && (ypos_q < V_VIS);
    hsync_d = !((xpos_q >= HS_FIRST) && (xpos_q <= HS_LAST));
    vsync_d = !((ypos_q >= VS_FIRST) && (ypos_q <= VS_LAST));
    tick_d  = (xpos_q == '0) && (ypos_q == V_VIS);
    red_d   = visible ? red_in   : '0;
    green_d = visible ? green_in : '0;
    blue_d  = visible ? blue_in  : '0;
  end

  always_ff @(posedge clk25 or posedge Reset) begin
    if (Reset) begin
      xpos_q  <= '0;
      ypos_q  <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      tick_q  <= 1'b0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      xpos_q  <= xpos_d;
      ypos_q  <= ypos_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      tick_q  <= tick_d;
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  assign xpos       = xpos_q;
  assign ypos       = ypos_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign frame_tick = tick_q;
  assign red        = red_q;
  assign green      = green_q;
  assign blue       = blue_q;

endmodule

// File: tb/tb_vga_timing_2015.sv
// Directed bench: default-timing instance for line/reset behaviour, plus a
// short-frame instance (same horizontal timing, 55 lines) for whole-frame checks.
module tb_vga_timing_2015;
  localparam int SV_VIS = 48, SV_FRONT = 2, SV_SYNC = 2, SV_BACK = 3;

  logic       clk25 = 1'b0;
  logic       Reset = 1'b0;
  logic [2:0] red_in = 3'd7, green_in = 3'd5;
  logic [1:0] blue_in = 2'd3;

  logic [9:0] d_xpos, d_ypos, s_xpos, s_ypos;
  logic       d_hs, d_vs, d_ft, s_hs, s_vs, s_ft;
  logic [2:0] d_r, d_g, s_r, s_g;
  logic [1:0] d_b, s_b;

  int passed = 0, total = 0;

  vga_timing_2015 dut (
    .clk25(clk25), .Reset(Reset), .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .xpos(d_xpos), .ypos(d_ypos), .hsync(d_hs), .vsync(d_vs),
    .red(d_r), .green(d_g), .blue(d_b), .frame_tick(d_ft));

  vga_timing_2015 #(.V_VISIBLE(SV_VIS), .V_FRONT(SV_FRONT), .V_SYNC(SV_SYNC), .V_BACK(SV_BACK)) dut_s (
    .clk25(clk25), .Reset(Reset), .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .xpos(s_xpos), .ypos(s_ypos), .hsync(s_hs), .vsync(s_vs),
    .red(s_r), .green(s_g), .blue(s_b), .frame_tick(s_ft));

  always #20 clk25 = ~clk25;

  task automatic step();
    @(posedge clk25);
    @(negedge clk25);
  endtask

  task automatic test_reset();
    #2 Reset = 1'b1;
    #3;  // before the first clock edge: reset must act asynchronously
    total++;
    if ({d_xpos, d_ypos, d_hs, d_vs, d_r, d_g, d_b, d_ft} !== {10'd0, 10'd0, 1'b1, 1'b1, 3'd0, 3'd0, 2'd0, 1'b0})
      $display("FAIL reset_immediate got x=%0d y=%0d hs=%b vs=%b rgb=%0d/%0d/%0d ft=%b want 0 0 1 1 0/0/0 0",
               d_xpos, d_ypos, d_hs, d_vs, d_r, d_g, d_b, d_ft);
    else passed++;
    repeat (3) step();
    total++;
    if ({d_xpos, d_ypos, d_hs, d_vs, d_r, d_g, d_b, d_ft, s_xpos, s_ypos} !==
        {10'd0, 10'd0, 1'b1, 1'b1, 3'd0, 3'd0, 2'd0, 1'b0, 10'd0, 10'd0})
      $display("FAIL reset_held got x=%0d y=%0d hs=%b vs=%b rgb=%0d/%0d/%0d ft=%b sx=%0d sy=%0d want all idle",
               d_xpos, d_ypos, d_hs, d_vs, d_r, d_g, d_b, d_ft, s_xpos, s_ypos);
    else passed++;
  endtask

  // Line 0 after release: first-edge state, visible/blank colour boundary, line wrap.
  task automatic test_line0();
    Reset = 1'b0;
    step();
    total++;
    if ({d_xpos, d_ypos, d_hs, d_vs, d_r, d_g, d_b} !== {10'd1, 10'd0, 1'b1, 1'b1, 3'd7, 3'd5, 2'd3})
      $display("FAIL first_edge got x=%0d y=%0d hs=%b vs=%b rgb=%0d/%0d/%0d want 1 0 1 1 7/5/3",
               d_xpos, d_ypos, d_hs, d_vs, d_r, d_g, d_b);
    else passed++;
    for (int e = 2; e <= 800; e++) begin
      step();
      if (e == 640) begin
        total++;
        if ({d_xpos, d_r, d_g, d_b} !== {10'd640, 3'd7, 3'd5, 2'd3})
          $display("FAIL colour_last_visible got x=%0d rgb=%0d/%0d/%0d want 640 7/5/3", d_xpos, d_r, d_g, d_b);
        else passed++;
      end
      if (e == 641) begin
        total++;
        if ({d_xpos, d_r, d_g, d_b} !== {10'd641, 3'd0, 3'd0, 2'd0})
          $display("FAIL colour_first_blank got x=%0d rgb=%0d/%0d/%0d want 641 0/0/0", d_xpos, d_r, d_g, d_b);
        else passed++;
      end
    end
    total++;
    if ({d_xpos, d_ypos, s_xpos, s_ypos} !== {10'd0, 10'd1, 10'd0, 10'd1})
      $display("FAIL line_wrap got x=%0d y=%0d sx=%0d sy=%0d want 0 1 0 1", d_xpos, d_ypos, s_xpos, s_ypos);
    else passed++;
  endtask

  task automatic test_hsync();
    int lows = 0, first_low = -1, back_high = -1, bad = 0;
    logic prev = 1'b1;
    for (int i = 0; i < 800; i++) begin
      step();
      if (d_hs === 1'b0) lows++;
      if (d_hs === 1'b0 && prev === 1'b1) first_low = int'(d_xpos);
      if (d_hs === 1'b1 && prev === 1'b0) back_high = int'(d_xpos);
      if (d_hs !== !(d_xpos >= 10'd657 && d_xpos <= 10'd752)) bad++;
      prev = d_hs;
    end
    total++;
    if (lows != 96 || first_low != 657 || back_high != 753)
      $display("FAIL hsync_window got lows=%0d first=%0d high_again=%0d want 96 657 753", lows, first_low, back_high);
    else passed++;
    total++;
    if (bad != 0) $display("FAIL hsync_per_cycle got %0d wrong cycles want 0", bad);
    else passed++;
  endtask

  task automatic test_toggle();
    int bad = 0;
    logic [9:0] px;
    logic [2:0] want;
    for (int i = 0; i < 800; i++) begin
      px = d_xpos;
      red_in = px[0] ? 3'd5 : 3'd2;
      step();
      want = (px < 10'd640) ? (px[0] ? 3'd5 : 3'd2) : 3'd0;
      if (d_r !== want) bad++;
    end
    red_in = 3'd7;
    total++;
    if (bad != 0 || d_ypos !== 10'd3)
      $display("FAIL red_toggle_lag got %0d wrong cycles y=%0d want 0 3", bad, d_ypos);
    else passed++;
  endtask

  // One full short frame starting at (0,3): sync window, frame tick, vertical blanking, wrap.
  task automatic test_frame();
    int vlows = 0, vfx = -1, vfy = -1, ticks = 0, tx = -1, ty = -1, blank_bad = 0, wraps = 0;
    logic prev = 1'b1;
    for (int i = 0; i < 55 * 800; i++) begin
      step();
      if (s_vs === 1'b0) vlows++;
      if (s_vs === 1'b0 && prev === 1'b1) begin vfx = int'(s_xpos); vfy = int'(s_ypos); end
      prev = s_vs;
      if (s_ft === 1'b1) begin ticks++; tx = int'(s_xpos); ty = int'(s_ypos); end
      if (s_ypos >= 10'd48 && {s_r, s_g, s_b} !== 8'd0) blank_bad++;
      if (s_xpos === 10'd0 && s_ypos === 10'd0) wraps++;
    end
    total++;
    if (vlows != 1600 || vfx != 1 || vfy != 50)
      $display("FAIL vsync_window got lows=%0d start=(%0d,%0d) want 1600 (1,50)", vlows, vfx, vfy);
    else passed++;
    total++;
    if (ticks != 1 || tx != 1 || ty != 48)
      $display("FAIL frame_tick got count=%0d at=(%0d,%0d) want 1 (1,48)", ticks, tx, ty);
    else passed++;
    total++;
    if (blank_bad != 0) $display("FAIL vertical_blank got %0d coloured cycles want 0", blank_bad);
    else passed++;
    total++;
    if (wraps != 1 || {s_xpos, s_ypos, d_xpos, d_ypos} !== {10'd0, 10'd3, 10'd0, 10'd58})
      $display("FAIL frame_wrap got wraps=%0d s=(%0d,%0d) d=(%0d,%0d) want 1 (0,3) (0,58)",
               wraps, s_xpos, s_ypos, d_xpos, d_ypos);
    else passed++;
  endtask

  task automatic test_async_reset();
    repeat (42 * 800 + 300) step();
    total++;
    if ({d_xpos, d_ypos, d_r} !== {10'd300, 10'd100, 3'd7})
      $display("FAIL pre_reset_pos got x=%0d y=%0d r=%0d want 300 100 7", d_xpos, d_ypos, d_r);
    else passed++;
    #5 Reset = 1'b1;
    #1;
    total++;
    if ({d_xpos, d_ypos, d_hs, d_vs, d_r, d_g, d_b, d_ft} !== {10'd0, 10'd0, 1'b1, 1'b1, 3'd0, 3'd0, 2'd0, 1'b0})
      $display("FAIL midframe_reset got x=%0d y=%0d hs=%b vs=%b rgb=%0d/%0d/%0d ft=%b want 0 0 1 1 0/0/0 0",
               d_xpos, d_ypos, d_hs, d_vs, d_r, d_g, d_b, d_ft);
    else passed++;
    @(negedge clk25);
    Reset = 1'b0;
    step();
    total++;
    if ({d_xpos, d_ypos, d_r, s_xpos, s_ypos} !== {10'd1, 10'd0, 3'd7, 10'd1, 10'd0})
      $display("FAIL resume_after_reset got x=%0d y=%0d r=%0d sx=%0d sy=%0d want 1 0 7 1 0",
               d_xpos, d_ypos, d_r, s_xpos, s_ypos);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_line0();
    test_hsync();
    test_toggle();
    test_frame();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/vga_timing_2015.md
VGA_TIMING_2015 -- requirements
Module: vga_timing_2015

Interface
REQ-001 H_VISIBLE, 640, visible pixels per line.
REQ-002 H_FRONT, 16, horizontal front porch in pixels.
REQ-003 H_SYNC, 96, horizontal sync width in pixels.
REQ-004 H_BACK, 48, horizontal back porch in pixels (line total 800).
REQ-005 V_VISIBLE, 480, visible lines per frame.
REQ-006 V_FRONT, 10, vertical front porch in lines.
REQ-007 V_SYNC, 2, vertical sync width in lines.
REQ-008 V_BACK, 33, vertical back porch in lines (frame total 525).
REQ-009 The block SHALL have one clock and an asynchronous, active-high reset: clk25 input 1 (25 MHz pixel clock, rising edge), then Reset input 1.
REQ-010 red_in  input  3  pixel colour from the game logic for the current xpos/ypos.
REQ-011 green_in  input  3  as red_in.
REQ-012 blue_in  input  2  as red_in.
REQ-013 xpos  output  10  current horizontal count, 0..799.
REQ-014 ypos  output  10  current vertical count, 0..524.
REQ-015 hsync  output  1  horizontal sync, active low.
REQ-016 vsync  output  1  vertical sync, active low.
REQ-017 red  output  3  registered, blanked colour to the DAC.
REQ-018 green  output  3  as red.
REQ-019 blue  output  2  as red.
REQ-020 frame_tick  output  1  one-cycle pulse at the start of vertical blanking.

Function
REQ-021 xpos SHALL increment by 1 every clk25 edge; at H total-1 (799) it SHALL wrap to 0.
REQ-022 ypos SHALL increment by 1 only on the edge where xpos wraps; at V total-1 (524) with xpos 799 it SHALL wrap to 0.
REQ-023 Both counters SHALL be registers driven straight to the ports, with no combinational path from inputs.
REQ-024 Pipeline: the pixel addressed in cycle n is sampled at the end of cycle n, and red/green/blue, hsync, vsync and frame_tick for that pixel SHALL appear in cycle n+1; latency is exactly 1 clock for all of them.
REQ-025 hsync SHALL be low in cycle n+1 iff xpos in cycle n is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] = [656,751].
REQ-026 vsync SHALL be low in cycle n+1 iff ypos in cycle n is in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] = [490,491], for the full line.
REQ-027 Blanking: if xpos>=640 or ypos>=480 in cycle n, red/green/blue SHALL be 0 in cycle n+1; otherwise they SHALL equal red_in/green_in/blue_in sampled in cycle n.
REQ-028 frame_tick SHALL be 1 in cycle n+1 iff cycle n has xpos=0 and ypos=480; exactly one pulse per 420000-cycle frame.
REQ-029 Counter compares SHALL be full 10-bit; no intermediate sum exceeds 10 bits for the default parameters.
REQ-030 Simultaneous wrap (xpos 799, ypos 524) SHALL take both counters to 0 on the same edge.

Reset
REQ-031 While Reset=1: xpos=0, ypos=0, hsync=1, vsync=1, red=green=blue=0, frame_tick=0. These values SHALL apply immediately, without waiting for a clock edge.
REQ-032 On the first edge after Reset falls: xpos=1, and the outputs reflect pixel (0,0).
REQ-033 Reset asserted mid-frame SHALL abandon the frame; no partial sync pulse is stretched.

Verification
REQ-034 Release Reset -> after 1 edge xpos=1, ypos=0; after 800 edges xpos=0, ypos=1; after 420000 edges xpos=0, ypos=0.
REQ-035 Watch a full line -> hsync low for exactly 96 consecutive cycles, first low cycle while xpos=657, high again while xpos=753.
REQ-036 Watch a full frame -> vsync low for exactly 1600 cycles, starting the cycle xpos=1, ypos=490; frame_tick high once, in the cycle xpos=1, ypos=480.
REQ-037 Hold red_in=7, green_in=5, blue_in=3 -> outputs are 7/5/3 in the cycle after xpos=639,ypos=0; 0/0/0 in the cycle after xpos=640; 0/0/0 throughout lines 480..524.
REQ-038 Assert Reset asynchronously between edges at xpos=300, ypos=100 -> xpos/ypos=0, hsync=vsync=1, colours=0 before the next edge; counting resumes from 0 after release.
REQ-039 Drive red_in from a toggling pattern keyed on xpos[0] -> red alternates with exactly 1-cycle lag, confirming colour/sync alignment.
